// File: rtl/i2c_pkg.sv
// Shared I2C definitions: codec device address, R/W encoding and the receiver state set.
package i2c_pkg;
   localparam logic [6:0] I2C_ADDR_CODEC = 7'b0011010;
   localparam logic       I2C_RW_WRITE   = 1'b0;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_ADDR,
      RX_ADDR_ACK,
      RX_DATA,
      RX_DATA_ACK,
      RX_WAIT_STOP
   } i2c_rx_state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA with edge, START and STOP detection.
module i2c_line_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic sclk,
   input  logic sdat,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_s
);
   logic [1:0] scl_ff;
   logic [1:0] sda_ff;
   logic       scl_p;
   logic       sda_p;
   logic       scl_s;

   // Reset to an idle (released) bus so no edge appears when reset lifts on a quiet bus.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         scl_ff <= 2'b11;
         sda_ff <= 2'b11;
         scl_p  <= 1'b1;
         sda_p  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[0], sclk};
         sda_ff <= {sda_ff[0], sdat};
         scl_p  <= scl_ff[1];
         sda_p  <= sda_ff[1];
      end
   end

   assign scl_s    = scl_ff[1];
   assign sda_s    = sda_ff[1];
   assign scl_rise = scl_s & ~scl_p;
   assign scl_fall = ~scl_s & scl_p;
   assign start    = scl_s & ~sda_s & sda_p;
   assign stop     = scl_s & sda_s & ~sda_p;
endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: matches the device address, ACKs BYTE data bytes and
// presents the assembled word with a one-cycle valid pulse.
//
// state        | meaning
// RX_IDLE      | bus free, waiting for START
// RX_ADDR      | shifting in address + R/W bit
// RX_ADDR_ACK  | pulling SDA low for the address ACK clock
// RX_DATA      | shifting in a data byte
// RX_DATA_ACK  | pulling SDA low for a data ACK clock
// RX_WAIT_STOP | frame rejected or complete; ignore bus until START/STOP
module i2c_slave_receiver
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR = I2C_ADDR_CODEC,
   parameter int         BYTE = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sclk,
   inout  wire               io_sdat,
   output logic [BYTE*8-1:0] o_dat,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_err
);
   localparam int CW = $clog2(BYTE + 1);

   i2c_rx_state_t     state, state_nx;
   logic              sda_drive, drive_nx;
   logic              scl_rise, scl_fall, start, stop, sda_s;
   logic [3:0]        bit_cnt;
   logic [CW-1:0]     byte_cnt;
   logic [7:0]        shift;
   logic [BYTE*8-1:0] word;
   logic [BYTE*8+7:0] word_ext;
   logic [BYTE*8-1:0] word_nx;
   logic              frame_open;
   logic              bit_in, byte_full, data_done, word_done;

   i2c_line_sync u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .sclk     (i_sclk),
      .sdat     (io_sdat),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_s    (sda_s)
   );

   assign io_sdat   = sda_drive ? 1'b0 : 1'bz;

   assign bit_in    = (state == RX_ADDR || state == RX_DATA) && scl_rise && !bit_cnt[3];
   assign byte_full = (bit_cnt == 4'd8);
   assign data_done = (state == RX_DATA) && bit_in && (bit_cnt == 4'd7);
   assign word_done = data_done && (byte_cnt == CW'(BYTE - 1));
   assign word_ext  = {word, shift[6:0], sda_s};
   assign word_nx   = word_ext[BYTE*8-1:0];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state     <= RX_IDLE;
         sda_drive <= 1'b0;
      end else begin
         state     <= state_nx;
         sda_drive <= drive_nx;
      end
   end

   always_comb begin
      state_nx = state;
      drive_nx = sda_drive;
      if (start) begin
         state_nx = RX_ADDR;
         drive_nx = 1'b0;
      end else if (stop) begin
         state_nx = RX_IDLE;
         drive_nx = 1'b0;
      end else begin
         case (state)
            RX_ADDR:
               if (scl_fall && byte_full) begin
                  if (shift == {ADDR, I2C_RW_WRITE}) begin
                     state_nx = RX_ADDR_ACK;
                     drive_nx = 1'b1;
                  end else begin
                     state_nx = RX_WAIT_STOP;
                  end
               end
            RX_ADDR_ACK:
               if (scl_fall) begin
                  state_nx = RX_DATA;
                  drive_nx = 1'b0;
               end
            RX_DATA:
               if (scl_fall && byte_full) begin
                  state_nx = RX_DATA_ACK;
                  drive_nx = 1'b1;
               end
            RX_DATA_ACK:
               if (scl_fall) begin
                  drive_nx = 1'b0;
                  state_nx = (byte_cnt == CW'(BYTE)) ? RX_WAIT_STOP : RX_DATA;
               end
            default: ;
         endcase
      end
   end

   // frame_open marks an ACKed address whose word has not yet been delivered.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         word       <= '0;
         frame_open <= 1'b0;
         o_dat      <= '0;
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         if (start || stop) begin
            o_err      <= frame_open;
            frame_open <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            o_busy     <= start;
         end else begin
            if (bit_in) begin
               shift   <= {shift[6:0], sda_s};
               bit_cnt <= bit_cnt + 4'd1;
            end
            if (data_done) begin
               word     <= word_nx;
               byte_cnt <= byte_cnt + CW'(1);
            end
            if (word_done) begin
               o_dat      <= word_nx;
               o_valid    <= 1'b1;
               frame_open <= 1'b0;
            end
            if (state == RX_ADDR && state_nx == RX_ADDR_ACK)
               frame_open <= 1'b1;
            if (scl_fall && (state == RX_ADDR_ACK || state == RX_DATA_ACK))
               bit_cnt <= '0;
         end
      end
   end
endmodule
